flash_byte_reader: RTL and testbench

- Upstream memory stage for the basic CPU. Serves single-byte reads from the on-board SPI NOR flash through the CPU's enable/ready handshake.
- Takes an 11-bit program address plus a base offset and issues a standard READ (0x03) transaction in SPI mode 0.
- Returns one byte per request.
- Sits between the CPU fetch/retrieve states and the flash pins at top level.

---
 rtl/flash_byte_reader.sv | 147 ++++++++++++++
 tb/tb_flash_byte_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_byte_reader.sv
// rtl/flash_byte_reader.sv - single-byte SPI NOR READ (0x03) engine behind an enable/ready handshake
module flash_byte_reader #(
  parameter int unsigned STARTUP_WAIT = 1000000,
  parameter logic [23:0] BASE_ADDR    = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] flashReadAddr,
  input  logic        enableFlash,
  output logic [7:0]  flashByteRead,
  output logic        flashDataReady,
  output logic        flashClk,
  output logic        flashMosi,
  input  logic        flashMiso,
  output logic        flashCs
);

  // Startup counter counts 0..WAIT_LAST; a zero wait degenerates to a single cycle.
  localparam int unsigned WAIT_LAST = (STARTUP_WAIT > 0) ? STARTUP_WAIT - 1 : 0;
  localparam int unsigned CW        = (WAIT_LAST > 0) ? $clog2(WAIT_LAST + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST_C = CW'(WAIT_LAST);
  localparam logic [CW-1:0] WAIT_ONE    = CW'(1);

  // FINISH is the single CS-low, SCK-low cycle after the last sample edge.
  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_SHIFT_OUT,
    ST_SHIFT_IN,
    ST_FINISH,
    ST_WAIT_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   shift_q, shift_d;     // command+address out, then received byte in [7:0]
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          phase_q, phase_d;     // 0 = SCK low half, 1 = SCK high half
  logic [7:0]    byte_q, byte_d;

  logic [23:0]   addr24;
  logic          bit_end;              // last cycle of a bit: the edge ending SCK-high
  logic          wait_done;

  assign addr24    = BASE_ADDR + {13'b0, flashReadAddr};
  assign bit_end   = phase_q;
  assign wait_done = (wait_cnt_q == WAIT_LAST_C);

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_STARTUP;
      wait_cnt_q <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      byte_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      byte_q     <= byte_d;
    end
  end

  // Next-state logic: one transaction per request, held enable parks in WAIT_RELEASE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STARTUP:      if (wait_done) state_d = ST_IDLE;
      ST_IDLE:         if (enableFlash) state_d = ST_SHIFT_OUT;
      ST_SHIFT_OUT:    if (bit_end && (bit_cnt_q == 5'd31)) state_d = ST_SHIFT_IN;
      ST_SHIFT_IN:     if (bit_end && (bit_cnt_q == 5'd7)) state_d = ST_FINISH;
      ST_FINISH:       state_d = enableFlash ? ST_WAIT_RELEASE : ST_IDLE;
      ST_WAIT_RELEASE: if (!enableFlash) state_d = ST_IDLE;
      default:         state_d = ST_STARTUP;
    endcase
  end

  // Datapath: startup count, request latch, bit timing and shifting, result capture.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    byte_d     = byte_q;
    case (state_q)
      ST_STARTUP: begin
        if (!wait_done) wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end
      ST_IDLE: begin
        if (enableFlash) begin
          shift_d   = {8'h03, addr24};
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end
      end
      ST_SHIFT_OUT: begin
        phase_d = ~phase_q;
        if (bit_end) begin
          shift_d   = {shift_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_SHIFT_IN: begin
        phase_d = ~phase_q;
        if (bit_end) begin
          shift_d   = {shift_q[30:0], flashMiso};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_FINISH: begin
        byte_d = shift_q[7:0];
      end
      default: begin
      end
    endcase
  end

  // Outputs decoded from registered state; SCK is gated to the CS-low states only.
  always_comb begin
    flashCs        = 1'b1;
    flashClk       = 1'b0;
    flashMosi      = 1'b0;
    flashDataReady = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT_RELEASE: flashDataReady = 1'b1;
      ST_SHIFT_OUT: begin
        flashCs   = 1'b0;
        flashClk  = phase_q;
        flashMosi = shift_q[31];
      end
      ST_SHIFT_IN: begin
        flashCs  = 1'b0;
        flashClk = phase_q;
      end
      ST_FINISH: flashCs = 1'b0;
      default: begin
      end
    endcase
  end

  assign flashByteRead = byte_q;

endmodule

// File: tb/tb_flash_byte_reader.sv
// tb/tb_flash_byte_reader.sv - directed bench for flash_byte_reader with a behavioural SPI NOR model
module tb_flash_byte_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] addr    [2];
  logic        en      [2];
  logic [7:0]  rd_byte [2];
  logic        ready   [2];
  logic        f_clk   [2];
  logic        f_mosi  [2];
  logic        f_miso  [2];
  logic        f_cs    [2];

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;
  int w0;

  always #5 clk = ~clk;

  flash_byte_reader #(.STARTUP_WAIT(20), .BASE_ADDR(24'h000000)) u_dut_a (
    .clk(clk), .reset(reset), .flashReadAddr(addr[0]), .enableFlash(en[0]),
    .flashByteRead(rd_byte[0]), .flashDataReady(ready[0]), .flashClk(f_clk[0]),
    .flashMosi(f_mosi[0]), .flashMiso(f_miso[0]), .flashCs(f_cs[0])
  );

  flash_byte_reader #(.STARTUP_WAIT(20), .BASE_ADDR(24'hFFFFFE)) u_dut_b (
    .clk(clk), .reset(reset), .flashReadAddr(addr[1]), .enableFlash(en[1]),
    .flashByteRead(rd_byte[1]), .flashDataReady(ready[1]), .flashClk(f_clk[1]),
    .flashMosi(f_mosi[1]), .flashMiso(f_miso[1]), .flashCs(f_cs[1])
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000005: return 8'hA7;
      24'h000001: return 8'h5C;
      default:    return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  // Flash model: samples MOSI on SCK rise, drives MISO after SCK fall (mode 0).
  for (genvar g = 0; g < 2; g++) begin : g_flash
    logic [31:0] rx = '0;
    logic [7:0]  data = '0;
    logic        miso_r = 1'b0;
    int bits = 0;
    int pulses = 0;
    int windows = 0;
    int sck_cs_high = 0;
    assign f_miso[g] = miso_r;
    always @(negedge f_cs[g] or posedge f_clk[g]) begin
      if (f_clk[g] === 1'b1) begin
        if (f_cs[g] !== 1'b0) sck_cs_high = sck_cs_high + 1;
        else begin
          pulses = pulses + 1;
          if (bits < 32) rx = {rx[30:0], f_mosi[g]};
          bits = bits + 1;
        end
      end else begin
        bits = 0;
        pulses = 0;
        windows = windows + 1;
      end
    end
    always @(negedge f_clk[g]) begin
      if (f_cs[g] === 1'b0 && bits >= 32 && bits < 40) begin
        data = mem_byte(rx[23:0]);
        miso_r <= data[3'(39 - bits)];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int idx, output int cycles);
    cycles = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (ready[idx] === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    en[0] = 1'b1; addr[0] = 11'h005;
    en[1] = 1'b0; addr[1] = 11'h003;

    // Reset values
    step();
    check("rst_ready", 32'(ready[0]), 0);
    check("rst_cs", 32'(f_cs[0]), 1);
    check("rst_sck", 32'(f_clk[0]), 0);
    check("rst_mosi", 32'(f_mosi[0]), 0);
    check("rst_byte", 32'(rd_byte[0]), 0);
    step();
    reset = 1'b1;

    // Startup gating with enable already held
    for (int i = 1; i <= 19; i++) begin
      step();
      check("startup_ready", 32'(ready[0]), 0);
    end
    step();
    check("startup_done_ready", 32'(ready[0]), 1);
    check("startup_done_cs", 32'(f_cs[0]), 1);
    w0 = g_flash[0].windows;

    // Basic read: accept on first IDLE cycle
    step();
    check("accept_ready_low", 32'(ready[0]), 0);
    check("accept_cs_low", 32'(f_cs[0]), 0);
    wait_ready(0, lat);
    check("basic_latency", 32'(lat), 81);
    check("basic_byte", 32'(rd_byte[0]), 32'hA7);
    check("basic_mosi_stream", g_flash[0].rx, 32'h03000005);
    check("basic_sck_pulses", 32'(g_flash[0].pulses), 40);
    check("basic_cs_release", 32'(f_cs[0]), 1);
    check("basic_sck_idle", 32'(f_clk[0]), 0);

    // Held enable: single CS window
    for (int i = 1; i <= 300; i++) step();
    check("held_windows", 32'(g_flash[0].windows - w0), 1);
    check("held_ready", 32'(ready[0]), 1);
    check("held_cs", 32'(f_cs[0]), 1);
    check("held_byte", 32'(rd_byte[0]), 32'hA7);
    en[0] = 1'b0; addr[0] = 11'h006;
    step();
    check("release_ready", 32'(ready[0]), 1);
    en[0] = 1'b1;
    step();
    check("second_accept_ready", 32'(ready[0]), 0);
    wait_ready(0, lat);
    check("second_latency", 32'(lat), 81);
    check("second_byte", 32'(rd_byte[0]), 32'h3A);
    check("second_mosi_stream", g_flash[0].rx, 32'h03000006);
    check("second_windows", 32'(g_flash[0].windows - w0), 2);
    en[0] = 1'b0;
    step();

    // Early enable drop and post-accept address change
    addr[0] = 11'h123; en[0] = 1'b1;
    step();
    check("drop_accept_ready", 32'(ready[0]), 0);
    check("byte_hold_on_accept", 32'(rd_byte[0]), 32'h3A);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) addr[0] = 11'h7FF;
    end
    en[0] = 1'b0;
    wait_ready(0, lat);
    check("drop_latency", 32'(lat), 71);
    check("drop_byte", 32'(rd_byte[0]), 32'h1F);
    check("drop_mosi_stream", g_flash[0].rx, 32'h03000123);

    // Back in IDLE directly: re-accept at A+82
    addr[0] = 11'h005; en[0] = 1'b1;
    step();
    check("reaccept_ready", 32'(ready[0]), 0);
    check("reaccept_cs", 32'(f_cs[0]), 0);

    // Abort during SHIFT_IN bit 3
    for (int i = 1; i <= 70; i++) step();
    check("abort_bits_seen", 32'(g_flash[0].bits), 35);
    check("abort_prev_byte", 32'(rd_byte[0]), 32'h1F);
    reset = 1'b0;
    step();
    check("abort_cs", 32'(f_cs[0]), 1);
    check("abort_sck", 32'(f_clk[0]), 0);
    check("abort_ready", 32'(ready[0]), 0);
    check("abort_byte", 32'(rd_byte[0]), 0);
    reset = 1'b1;
    for (int i = 1; i <= 19; i++) step();
    check("restart_ready_low", 32'(ready[0]), 0);
    step();
    check("restart_ready_high", 32'(ready[0]), 1);
    step();
    wait_ready(0, lat);
    check("restart_latency", 32'(lat), 81);
    check("restart_byte", 32'(rd_byte[0]), 32'hA7);
    en[0] = 1'b0;
    step();
    check("sck_while_cs_high_a", 32'(g_flash[0].sck_cs_high), 0);

    // Base offset wrap on second instance
    en[1] = 1'b1;
    step();
    check("base_accept_ready", 32'(ready[1]), 0);
    wait_ready(1, lat);
    check("base_latency", 32'(lat), 81);
    check("base_mosi_stream", g_flash[1].rx, 32'h03000001);
    check("base_byte", 32'(rd_byte[1]), 32'h5C);
    check("base_sck_pulses", 32'(g_flash[1].pulses), 40);
    en[1] = 1'b0;
    step();
    check("base_idle_ready", 32'(ready[1]), 1);
    check("sck_while_cs_high_b", 32'(g_flash[1].sck_cs_high), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
